// File: rtl/tg_port_arbiter.sv
// Two-port round-robin command arbiter for the traffic generator.
// Read-return routing uses a 1-bit port-ID tag FIFO.
module tg_port_arbiter #(
  parameter int TCQ                = 100,
  parameter int APP_DATA_WIDTH_2_1 = 64,
  parameter int APP_ADDR_WIDTH     = 32,
  parameter int APP_CMD_WIDTH      = 3,
  parameter int TAG_DEPTH          = 16,
  parameter int LOG2_TAG_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tg0_en,
  input  logic [APP_CMD_WIDTH-1:0]        tg0_cmd,
  input  logic [APP_ADDR_WIDTH-1:0]       tg0_addr,
  input  logic [APP_DATA_WIDTH_2_1-1:0]   tg0_wdf_data,
  output logic                            tg0_rdy,
  output logic                            tg0_rd_data_valid,
  output logic [APP_DATA_WIDTH_2_1-1:0]   tg0_rd_data,
  input  logic                            tg1_en,
  input  logic [APP_CMD_WIDTH-1:0]        tg1_cmd,
  input  logic [APP_ADDR_WIDTH-1:0]       tg1_addr,
  input  logic [APP_DATA_WIDTH_2_1-1:0]   tg1_wdf_data,
  output logic                            tg1_rdy,
  output logic                            tg1_rd_data_valid,
  output logic [APP_DATA_WIDTH_2_1-1:0]   tg1_rd_data,
  output logic                            tg_en,
  output logic [APP_CMD_WIDTH-1:0]        tg_cmd,
  output logic [APP_ADDR_WIDTH-1:0]       tg_addr,
  output logic [APP_DATA_WIDTH_2_1-1:0]   tg_wdf_data,
  output logic                            tg_wdf_wren,
  output logic                            tg_wdf_end,
  output logic [APP_DATA_WIDTH_2_1/8-1:0] tg_wdf_mask,
  input  logic                            tg_rdy,
  input  logic                            tg_rd_data_valid,
  input  logic [APP_DATA_WIDTH_2_1-1:0]   tg_rd_data,
  output logic                            tag_err
);

  localparam logic [APP_CMD_WIDTH-1:0] CMD_WR = '0;
  localparam logic [APP_CMD_WIDTH-1:0] CMD_RD = 1;
  localparam logic [LOG2_TAG_DEPTH:0]  FULL_CNT = TAG_DEPTH[LOG2_TAG_DEPTH:0];

  logic [TAG_DEPTH-1:0]        r_tags;
  logic [LOG2_TAG_DEPTH-1:0]   r_wr_ptr;
  logic [LOG2_TAG_DEPTH-1:0]   r_rd_ptr;
  logic [LOG2_TAG_DEPTH:0]     r_cnt;
  logic                        r_last;
  logic                        r_err;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_blk;
  logic w_el0;
  logic w_el1;
  logic w_gnt;
  logic w_xfer;
  logic w_push;
  logic w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = tg_rd_data_valid && !w_empty;
  assign w_head  = r_tags[r_rd_ptr];

  // A full FIFO only blocks reads when no return frees a slot this cycle.
  assign w_blk = w_full && !w_pop;
  assign w_el0 = tg0_en && !((tg0_cmd == CMD_RD) && w_blk);
  assign w_el1 = tg1_en && !((tg1_cmd == CMD_RD) && w_blk);

  always_comb begin
    w_gnt = 1'b0;
    if (w_el0 && w_el1) w_gnt = ~r_last;
    else if (w_el1)     w_gnt = 1'b1;
  end

  assign tg_en       = w_el0 || w_el1;
  assign tg_cmd      = w_gnt ? tg1_cmd      : tg0_cmd;
  assign tg_addr     = w_gnt ? tg1_addr     : tg0_addr;
  assign tg_wdf_data = w_gnt ? tg1_wdf_data : tg0_wdf_data;
  assign tg_wdf_wren = tg_en && (tg_cmd == CMD_WR);
  assign tg_wdf_end  = tg_wdf_wren;
  assign tg_wdf_mask = '0;

  assign w_xfer  = tg_en && tg_rdy;
  assign w_push  = w_xfer && (tg_cmd == CMD_RD);
  assign tg0_rdy = w_xfer && !w_gnt;
  assign tg1_rdy = w_xfer &&  w_gnt;

  assign tg0_rd_data_valid = w_pop && !w_head;
  assign tg1_rd_data_valid = w_pop &&  w_head;
  assign tg0_rd_data       = tg_rd_data;
  assign tg1_rd_data       = tg_rd_data;
  assign tag_err           = r_err;

  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= w_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_xfer) r_last <= w_gnt;
      if (tg_rd_data_valid && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tg_port_arbiter.sv
// Directed table-driven bench for tg_port_arbiter.
// Hand-written sequences cover reset and tag error behaviour.
module tb_tg_port_arbiter;

  localparam logic [2:0] W = 3'b000;
  localparam logic [2:0] R = 3'b001;
  localparam logic [63:0] D0 = 64'hA0A0_0000_1111_0000;
  localparam logic [63:0] D1 = 64'hB1B1_0000_2222_0001;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tg0_en = 1'b0, tg1_en = 1'b0;
  logic [2:0]  tg0_cmd = W, tg1_cmd = W;
  logic [31:0] tg0_addr = A0, tg1_addr = A1;
  logic [63:0] tg0_wdf_data = D0, tg1_wdf_data = D1;
  logic        tg0_rdy, tg1_rdy;
  logic        tg0_rd_data_valid, tg1_rd_data_valid;
  logic [63:0] tg0_rd_data, tg1_rd_data;
  logic        tg_en;
  logic [2:0]  tg_cmd;
  logic [31:0] tg_addr;
  logic [63:0] tg_wdf_data;
  logic        tg_wdf_wren, tg_wdf_end;
  logic [7:0]  tg_wdf_mask;
  logic        tg_rdy = 1'b0;
  logic        tg_rd_data_valid = 1'b0;
  logic [63:0] tg_rd_data = '0;
  logic        tag_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tg_port_arbiter dut (
    .clk(clk), .rst(rst),
    .tg0_en(tg0_en), .tg0_cmd(tg0_cmd), .tg0_addr(tg0_addr),
    .tg0_wdf_data(tg0_wdf_data), .tg0_rdy(tg0_rdy),
    .tg0_rd_data_valid(tg0_rd_data_valid), .tg0_rd_data(tg0_rd_data),
    .tg1_en(tg1_en), .tg1_cmd(tg1_cmd), .tg1_addr(tg1_addr),
    .tg1_wdf_data(tg1_wdf_data), .tg1_rdy(tg1_rdy),
    .tg1_rd_data_valid(tg1_rd_data_valid), .tg1_rd_data(tg1_rd_data),
    .tg_en(tg_en), .tg_cmd(tg_cmd), .tg_addr(tg_addr),
    .tg_wdf_data(tg_wdf_data), .tg_wdf_wren(tg_wdf_wren),
    .tg_wdf_end(tg_wdf_end), .tg_wdf_mask(tg_wdf_mask),
    .tg_rdy(tg_rdy), .tg_rd_data_valid(tg_rd_data_valid),
    .tg_rd_data(tg_rd_data), .tag_err(tag_err)
  );

  typedef struct {
    bit          e0;
    logic [2:0]  c0;
    bit          e1;
    logic [2:0]  c1;
    bit          rdy;
    bit          rv;
    logic [63:0] rd;
    bit          xen;
    bit          xg;
    bit          xr0;
    bit          xr1;
    bit          xw;
    bit          xv0;
    bit          xv1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit e0, logic [2:0] c0, bit e1, logic [2:0] c1,
    bit rdy, bit rv, logic [63:0] rd,
    bit xen, bit xg, bit xr0, bit xr1, bit xw, bit xv0, bit xv1);
    vec_t v;
    v.e0 = e0; v.c0 = c0; v.e1 = e1; v.c1 = c1;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.xen = xen; v.xg = xg; v.xr0 = xr0; v.xr1 = xr1;
    v.xw = xw; v.xv0 = xv0; v.xv1 = xv1;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    tg0_en = v.e0; tg0_cmd = v.c0;
    tg1_en = v.e1; tg1_cmd = v.c1;
    tg_rdy = v.rdy; tg_rd_data_valid = v.rv; tg_rd_data = v.rd;
  endtask

  task automatic apply(int idx, vec_t v);
    string p;
    @(negedge clk);
    drive(v);
    #1;
    p = $sformatf("v%0d", idx);
    chk({p, ".tg_en"}, tg_en, v.xen);
    chk({p, ".rdy0"}, tg0_rdy, v.xr0);
    chk({p, ".rdy1"}, tg1_rdy, v.xr1);
    chk({p, ".wren"}, tg_wdf_wren, v.xw);
    chk({p, ".wend"}, tg_wdf_end, v.xw);
    chk({p, ".v0"}, tg0_rd_data_valid, v.xv0);
    chk({p, ".v1"}, tg1_rd_data_valid, v.xv1);
    chk({p, ".err"}, tag_err, 1'b0);
    chk({p, ".rd0"}, tg0_rd_data, v.rd);
    chk({p, ".rd1"}, tg1_rd_data, v.rd);
    if (v.xen) begin
      chk({p, ".addr"}, tg_addr, v.xg ? A1 : A0);
      chk({p, ".wdata"}, tg_wdf_data, v.xg ? D1 : D0);
      chk({p, ".cmd"}, tg_cmd, v.xg ? v.c1 : v.c0);
    end
  endtask

  task automatic idle();
    tg0_en = 0; tg1_en = 0; tg0_cmd = W; tg1_cmd = W;
    tg_rdy = 0; tg_rd_data_valid = 0; tg_rd_data = '0;
  endtask

  initial begin
    // alternating writes; port 0 wins the first tie out of reset
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, W, 1, W, 1, 0, '0,
                       1, i[0], !i[0], i[0], 1, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, R, 0, W, 1, 0, '0, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, R, 0, R, 1, 1, 64'hC000 + i,
                       0, 0, 0, 0, 0, 1, 0));
    // stalled downstream: last_grant=0 so port 1 is selected
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, W, 1, W, 0, 0, '0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, W, 1, W, 1, 0, '0, 1, 1, 0, 1, 1, 0, 0));
    // interleaved reads and their routed returns
    tbl.push_back(mk(1, R, 0, W, 1, 0, '0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, W, 1, R, 1, 0, '0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, R, 0, W, 1, 0, '0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, W, 0, W, 1, 1, 64'hD0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, W, 0, W, 1, 1, 64'hD1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, W, 0, W, 1, 1, 64'hD2, 0, 0, 0, 0, 0, 1, 0));
    // fill the tag FIFO
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, R, 0, W, 1, 0, '0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, R, 1, W, 1, 0, '0, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, R, 0, W, 1, 0, '0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, R, 0, W, 1, 1, 64'hE0, 1, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, W, 0, W, 1, 1, 64'hF00 + i,
                       0, 0, 0, 0, 0, 1, 0));

    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.tag_err", tag_err, 1'b0);
    chk("rst.mask", tg_wdf_mask, 8'h00);
    rst = 0;

    foreach (tbl[i]) apply(i, tbl[i]);

    // empty FIFO, return arrives: no routing, sticky error
    @(negedge clk);
    idle();
    tg_rdy = 1; tg_rd_data_valid = 1; tg_rd_data = 64'h99;
    #1;
    chk("err.v0", tg0_rd_data_valid, 1'b0);
    chk("err.v1", tg1_rd_data_valid, 1'b0);
    @(negedge clk);
    tg_rd_data_valid = 0;
    #1;
    chk("err.set", tag_err, 1'b1);
    repeat (3) @(negedge clk);
    chk("err.sticky", tag_err, 1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("err.clr", tag_err, 1'b0);

    // mid-operation reset discards outstanding tags
    tg0_en = 1; tg0_cmd = R; tg_rdy = 1;
    #1;
    chk("mid.rdy0", tg0_rdy, 1'b1);
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    tg0_en = 1; tg1_en = 1;
    #1;
    chk("mid.tie", tg_addr, A0);
    tg0_en = 0; tg1_en = 0;
    tg_rd_data_valid = 1;
    #1;
    chk("mid.v0", tg0_rd_data_valid, 1'b0);
    @(negedge clk);
    tg_rd_data_valid = 0;
    #1;
    chk("mid.err", tag_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
